// File: rtl/ctl_trigger_multi.sv
// ctl_trigger_multi: per-channel gun/mouse trigger controller with debounce, hit window, cooldown and saturating counters
module ctl_trigger_multi #(
    parameter int N_CH            = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HIT_WINDOW      = 16,
    parameter int COOLDOWN        = 32,
    parameter int CNT_W           = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       gun_is_connected,
    input  logic [N_CH-1:0]       gun_trigger,
    input  logic [N_CH-1:0]       gun_photodetector,
    input  logic [N_CH-1:0]       mouse_left,
    input  logic [N_CH-1:0]       mouse_on_target,
    output logic [N_CH-1:0]       flash_req,
    output logic [N_CH-1:0]       shot_fired,
    output logic [N_CH-1:0]       hit,
    output logic [N_CH-1:0]       miss,
    output logic [N_CH*CNT_W-1:0] shot_count,
    output logic [N_CH*CNT_W-1:0] hit_count
);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TM_MX = (HIT_WINDOW > COOLDOWN) ? HIT_WINDOW : COOLDOWN;
    localparam int TM_W  = $clog2(TM_MX + 1);

    typedef enum logic [1:0] {S_IDLE, S_FLASH, S_RESULT, S_COOL} state_t;

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_ch
            logic [1:0]       r_trig_sync;
            logic [1:0]       r_pd_sync;
            logic [DB_W-1:0]  r_db_cnt;
            logic             r_deb;
            logic             r_deb_q;
            logic             r_ml_q;
            logic             r_flag;
            logic             r_flash;
            logic             r_shot;
            logic             r_hit;
            logic             r_miss;
            logic [TM_W-1:0]  r_tmr;
            logic [CNT_W-1:0] r_shots;
            logic [CNT_W-1:0] r_hits;
            state_t           r_state;
            logic             w_gun;
            logic             w_shot;

            assign w_gun  = gun_is_connected[g];
            assign w_shot = w_gun ? (r_deb & ~r_deb_q) : (mouse_left[g] & ~r_ml_q);

            // synchronise the raw gun inputs, debounce the trigger and keep previous levels for edge detection
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_trig_sync <= '0;
                    r_pd_sync   <= '0;
                    r_db_cnt    <= '0;
                    r_deb       <= 1'b0;
                    r_deb_q     <= 1'b0;
                    r_ml_q      <= 1'b0;
                end else begin
                    r_trig_sync <= {r_trig_sync[0], gun_trigger[g]};
                    r_pd_sync   <= {r_pd_sync[0], gun_photodetector[g]};
                    r_deb_q     <= r_deb;
                    r_ml_q      <= mouse_left[g];
                    if (r_trig_sync[1] == r_deb) begin
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        r_deb    <= r_trig_sync[1];
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
            end

            // shot state machine with registered pulses and saturating counters
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_state <= S_IDLE;
                    r_tmr   <= '0;
                    r_flag  <= 1'b0;
                    r_flash <= 1'b0;
                    r_shot  <= 1'b0;
                    r_hit   <= 1'b0;
                    r_miss  <= 1'b0;
                    r_shots <= '0;
                    r_hits  <= '0;
                end else begin
                    r_shot <= 1'b0;
                    r_hit  <= 1'b0;
                    r_miss <= 1'b0;
                    case (r_state)
                        S_IDLE: begin
                            if (w_shot) begin
                                r_state <= w_gun ? S_FLASH : S_RESULT;
                                r_flash <= w_gun;
                                r_flag  <= ~w_gun & mouse_on_target[g];
                                r_tmr   <= '0;
                                r_shot  <= 1'b1;
                                if (r_shots != '1) r_shots <= r_shots + 1'b1;
                            end
                        end
                        S_FLASH: begin
                            if (!w_gun) begin
                                r_state <= S_IDLE;
                                r_flash <= 1'b0;
                            end else begin
                                r_flag <= r_flag | r_pd_sync[1];
                                if (r_tmr == TM_W'(HIT_WINDOW - 1)) begin
                                    r_state <= S_RESULT;
                                    r_flash <= 1'b0;
                                end else begin
                                    r_tmr <= r_tmr + 1'b1;
                                end
                            end
                        end
                        S_RESULT: begin
                            r_hit   <= r_flag;
                            r_miss  <= ~r_flag;
                            r_tmr   <= '0;
                            r_state <= S_COOL;
                            if (r_flag && r_hits != '1) r_hits <= r_hits + 1'b1;
                        end
                        S_COOL: begin
                            if (r_tmr == TM_W'(COOLDOWN - 1)) r_state <= S_IDLE;
                            else r_tmr <= r_tmr + 1'b1;
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end

            assign flash_req[g]                  = r_flash;
            assign shot_fired[g]                 = r_shot;
            assign hit[g]                        = r_hit;
            assign miss[g]                       = r_miss;
            assign shot_count[g*CNT_W +: CNT_W]  = r_shots;
            assign hit_count[g*CNT_W +: CNT_W]   = r_hits;
        end
    endgenerate
endmodule

// File: tb/tb_ctl_trigger_multi.sv
// tb_ctl_trigger_multi: scoreboard bench with a timestamp-based reference model of the trigger controller
module tb_ctl_trigger_multi;
    localparam int N    = 2;
    localparam int DEB  = 4;
    localparam int HW   = 16;
    localparam int CD   = 32;
    localparam int CW   = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [N-1:0] gic = '0, trig = '0, pd = '0, ml = '0, mot = '0;
    logic [N-1:0] flash_req, shot_fired, hit, miss;
    logic [N*CW-1:0] shot_count, hit_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ctl_trigger_multi #(
        .N_CH(N), .DEBOUNCE_CYCLES(DEB), .HIT_WINDOW(HW), .COOLDOWN(CD), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .gun_is_connected(gic), .gun_trigger(trig), .gun_photodetector(pd),
        .mouse_left(ml), .mouse_on_target(mot),
        .flash_req(flash_req), .shot_fired(shot_fired), .hit(hit), .miss(miss),
        .shot_count(shot_count), .hit_count(hit_count)
    );

    // kind: 0 none, 1 shot, 2 hit, 3 miss
    typedef struct {int cyc; int ch; int kind;} ev_t;
    ev_t evq[$];
    ev_t e_in, e_out;

    int k = 0;
    logic [63:0] t_hist [N];
    logic [63:0] p_hist [N];
    logic [63:0] mask, win;
    logic m_prev [N], deb [N], deb_old [N], flag [N], m_flash [N];
    int idle_at [N], res_at [N], flash_last [N], m_sc [N], m_hc [N];
    logic gshot, mshot;
    int exp_k [N];
    int got;

    task automatic chk(string nm, int c, int g, int e);
        n_checks++;
        if (g != e) begin
            n_errors++;
            $display("FAIL %s ch%0d cycle %0d: got %0d expected %0d", nm, c, k, g, e);
        end
    endtask

    // Reference model: channel timing expressed as absolute edge deadlines
    always @(posedge clk) begin
        k++;
        mask = (64'd1 << DEB) - 64'd1;
        for (int c = 0; c < N; c++) begin
            if (!rst) begin
                t_hist[c] = '0; p_hist[c] = '0; m_prev[c] = 0; deb[c] = 0; deb_old[c] = 0;
                flag[c] = 0; m_flash[c] = 0; idle_at[c] = 0; res_at[c] = -1;
                flash_last[c] = -1; m_sc[c] = 0; m_hc[c] = 0;
            end else begin
                gshot = deb[c] && !deb_old[c];
                mshot = ml[c] && !m_prev[c];
                if (k == res_at[c]) begin
                    e_in.cyc = k; e_in.ch = c; e_in.kind = flag[c] ? 2 : 3;
                    evq.push_back(e_in);
                    if (flag[c] && m_hc[c] < MAXC) m_hc[c]++;
                end else if (m_flash[c]) begin
                    if (!gic[c]) begin
                        m_flash[c] = 0; idle_at[c] = k + 1; res_at[c] = -1;
                    end else begin
                        flag[c] = flag[c] | p_hist[c][1];
                        if (k == flash_last[c]) m_flash[c] = 0;
                    end
                end else if (k >= idle_at[c] && (gic[c] ? gshot : mshot)) begin
                    e_in.cyc = k; e_in.ch = c; e_in.kind = 1;
                    evq.push_back(e_in);
                    if (m_sc[c] < MAXC) m_sc[c]++;
                    flag[c] = !gic[c] && mot[c];
                    if (gic[c]) begin
                        m_flash[c] = 1; flash_last[c] = k + HW;
                        res_at[c] = k + HW + 1; idle_at[c] = k + HW + CD + 2;
                    end else begin
                        res_at[c] = k + 1; idle_at[c] = k + CD + 2;
                    end
                end
                win = (t_hist[c] >> 1) & mask;
                deb_old[c] = deb[c];
                if (win == (deb[c] ? 64'd0 : mask)) deb[c] = !deb[c];
                t_hist[c] = {t_hist[c][62:0], trig[c]};
                p_hist[c] = {p_hist[c][62:0], pd[c]};
                m_prev[c] = ml[c];
            end
        end
    end

    // Monitor: pop expected pulses for this edge and compare all outputs
    always @(negedge clk) begin
        for (int c = 0; c < N; c++) exp_k[c] = 0;
        while (evq.size() > 0 && evq[0].cyc <= k) begin
            e_out = evq.pop_front();
            if (e_out.cyc == k) exp_k[e_out.ch] = e_out.kind;
            else chk("stale_event", e_out.ch, e_out.cyc, k);
        end
        if (k > 0) begin
            for (int c = 0; c < N; c++) begin
                got = shot_fired[c] ? 1 : hit[c] ? 2 : miss[c] ? 3 : 0;
                chk("pulse_kind", c, got, exp_k[c]);
                chk("pulse_excl", c, int'(shot_fired[c]) + int'(hit[c]) + int'(miss[c]) > 1, 0);
                chk("flash_req", c, int'(flash_req[c]), int'(m_flash[c]));
                chk("shot_count", c, int'(shot_count[c*CW +: CW]), m_sc[c]);
                chk("hit_count", c, int'(hit_count[c*CW +: CW]), m_hc[c]);
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic click(int c);
        ml[c] = 1'b1;
        cyc(1);
        ml[c] = 1'b0;
    endtask

    initial begin
        cyc(3);
        rst = 1'b1;
        gic = 2'b01;
        cyc(2);
        // gun hit on ch0
        trig[0] = 1'b1;
        cyc(11);
        pd[0] = 1'b1;
        cyc(3);
        pd[0] = 1'b0;
        cyc(60);
        // bouncy trigger, no photodetector
        trig[0] = 1'b0;
        cyc(10);
        for (int i = 0; i < 5; i++) begin
            trig[0] = ~trig[0];
            cyc(2);
        end
        trig[0] = 1'b1;
        cyc(80);
        // mouse on ch1: miss, then hit, then cooldown rejection
        click(1);
        cyc(33);
        mot[1] = 1'b1;
        click(1);
        cyc(10);
        click(1);
        cyc(40);
        click(1);
        cyc(40);
        // abort mid-flash by dropping gun mode on ch0
        trig[0] = 1'b0;
        cyc(10);
        trig[0] = 1'b1;
        cyc(12);
        gic[0] = 1'b0;
        cyc(5);
        // reset mid-flash on ch1
        gic = 2'b11;
        trig[1] = 1'b0;
        cyc(10);
        trig[1] = 1'b1;
        cyc(12);
        rst = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(5);
        // saturation with mouse hits on ch1
        gic[1] = 1'b0;
        mot[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            click(1);
            cyc(40);
        end
        // randomized traffic
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 7) == 0) trig[c] = ~trig[c];
                pd[c] = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 3) == 0) ml[c] = ~ml[c];
                mot[c] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 299) == 0) gic[c] = ~gic[c];
            end
            rst = ($urandom_range(0, 1499) != 0);
        end
        rst = 1'b1;
        cyc(5);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
